// File: rtl/axil_seq_master_if.sv
// Bundle of command/response and AXI4-Lite master signals for axil_seq_master.
// "master" is the sequencer side, "slave" is the command source plus AXI slave side.
interface axil_seq_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [DATA_W-1:0] cmd_mask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_resp;
    logic              rsp_timeout;
    logic              busy;
    logic              m_awvalid, m_awready;
    logic [ADDR_W-1:0] m_awaddr;
    logic              m_wvalid, m_wready;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic              m_bvalid, m_bready;
    logic [1:0]        m_bresp;
    logic              m_arvalid, m_arready;
    logic [ADDR_W-1:0] m_araddr;
    logic              m_rvalid, m_rready;
    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        m_rresp;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_resp, rsp_timeout, busy,
        output m_awvalid, m_awaddr, input m_awready,
        output m_wvalid, m_wdata, m_wstrb, input m_wready,
        input  m_bvalid, m_bresp, output m_bready,
        output m_arvalid, m_araddr, input m_arready,
        input  m_rvalid, m_rdata, m_rresp, output m_rready
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_resp, rsp_timeout, busy,
        input  m_awvalid, m_awaddr, output m_awready,
        input  m_wvalid, m_wdata, m_wstrb, output m_wready,
        output m_bvalid, m_bresp, input m_bready,
        input  m_arvalid, m_araddr, output m_arready,
        output m_rvalid, m_rdata, m_rresp, input m_rready
    );
endinterface

// File: rtl/axil_seq_master.sv
// Single-outstanding AXI4-Lite command sequencer: WRITE, READ, DELAY and
// POLL (masked compare with retry gap and attempt limit).
module axil_seq_master #(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h6000_0000),
    parameter int              POLL_MAX  = 16,
    parameter int              POLL_GAP  = 8
) (
    input  logic               axi_aclk,
    input  logic               axi_aresetn,
    axil_seq_master_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE, WR_AW_W, WR_B, RD_AR, RD_R, DLY, POLL_GAP_WAIT, RSP
    } state_t;

    localparam logic [1:0] OP_WR = 2'd0, OP_RD = 2'd1, OP_DLY = 2'd2, OP_POLL = 2'd3;
    localparam int PC_W = $clog2(POLL_MAX + 1);
    localparam logic [PC_W-1:0]   PC_LAST = PC_W'(POLL_MAX - 1);
    localparam logic [DATA_W-1:0] GAP_LD  = (POLL_GAP > 0) ? DATA_W'(POLL_GAP - 1) : '0;

    state_t              r_state, w_next;
    logic [1:0]          r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data, r_mask, r_cnt;
    logic [PC_W-1:0]     r_tries;
    logic                r_aw_done, r_w_done;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [1:0]          r_rsp_resp;
    logic                r_rsp_timeout;

    logic w_cmd_hs, w_aw_hs, w_w_hs, w_match, w_poll_last, w_rd_final;
    assign w_cmd_hs    = bus.cmd_valid && bus.cmd_ready;
    assign w_aw_hs     = bus.m_awvalid && bus.m_awready;
    assign w_w_hs      = bus.m_wvalid && bus.m_wready;
    assign w_match     = ((bus.m_rdata ^ r_data) & r_mask) == '0;
    assign w_poll_last = r_tries == PC_LAST;
    // A read beat ends the command unless it is a clean, non-matching, non-final poll
    assign w_rd_final  = (r_op != OP_POLL) || (bus.m_rresp != 2'b00) || w_match || w_poll_last;

    // cmd_ready is gated by reset so it reads 0 while reset is held
    assign bus.cmd_ready   = (r_state == IDLE) && axi_aresetn;
    assign bus.busy        = r_state != IDLE;
    assign bus.rsp_valid   = r_state == RSP;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_resp    = r_rsp_resp;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.m_awvalid   = (r_state == WR_AW_W) && !r_aw_done;
    assign bus.m_wvalid    = (r_state == WR_AW_W) && !r_w_done;
    assign bus.m_awaddr    = r_addr;
    assign bus.m_wdata     = r_data;
    assign bus.m_wstrb     = '1;
    assign bus.m_bready    = r_state == WR_B;
    assign bus.m_arvalid   = r_state == RD_AR;
    assign bus.m_araddr    = r_addr;
    assign bus.m_rready    = r_state == RD_R;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_cmd_hs) begin
                case (bus.cmd_op)
                    OP_WR:          w_next = WR_AW_W;
                    OP_RD, OP_POLL: w_next = RD_AR;
                    default:        w_next = DLY;
                endcase
            end
            WR_AW_W:       if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = WR_B;
            WR_B:          if (bus.m_bvalid) w_next = RSP;
            RD_AR:         if (bus.m_arready) w_next = RD_R;
            RD_R: if (bus.m_rvalid) begin
                if (w_rd_final)         w_next = RSP;
                else if (POLL_GAP == 0) w_next = RD_AR;
                else                    w_next = POLL_GAP_WAIT;
            end
            DLY:           if (r_cnt == '0) w_next = RSP;
            POLL_GAP_WAIT: if (r_cnt == '0) w_next = RD_AR;
            RSP:           if (bus.rsp_ready) w_next = IDLE;
            default:       w_next = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) r_state <= IDLE;
        else              r_state <= w_next;
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_op          <= OP_WR;
            r_addr        <= '0;
            r_data        <= '0;
            r_mask        <= '0;
            r_cnt         <= '0;
            r_tries       <= '0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_resp    <= 2'b00;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_cmd_hs) begin
                    r_op          <= bus.cmd_op;
                    r_addr        <= BASE_ADDR + bus.cmd_addr;
                    r_data        <= bus.cmd_data;
                    r_mask        <= bus.cmd_mask;
                    r_cnt         <= bus.cmd_data;
                    r_tries       <= '0;
                    r_aw_done     <= 1'b0;
                    r_w_done      <= 1'b0;
                    r_rsp_timeout <= 1'b0;
                end
                WR_AW_W: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                end
                WR_B: if (bus.m_bvalid) begin
                    r_rsp_data <= r_data;
                    r_rsp_resp <= bus.m_bresp;
                end
                RD_R: if (bus.m_rvalid) begin
                    r_rsp_data <= bus.m_rdata;
                    r_rsp_resp <= bus.m_rresp;
                    r_tries    <= r_tries + PC_W'(1);
                    r_cnt      <= GAP_LD;
                    if (r_op == OP_POLL && bus.m_rresp == 2'b00 && !w_match && w_poll_last)
                        r_rsp_timeout <= 1'b1;
                end
                DLY: begin
                    if (r_cnt == '0) begin
                        r_rsp_data <= '0;
                        r_rsp_resp <= 2'b00;
                    end else begin
                        r_cnt <= r_cnt - DATA_W'(1);
                    end
                end
                POLL_GAP_WAIT: if (r_cnt != '0) r_cnt <= r_cnt - DATA_W'(1);
                default: ;
            endcase
        end
    end
endmodule
